// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one FIFO write port between NUM_REQ producers.
// Optional accepted-beat/packet counters are built when FIFO_WR_ARB_CNT_EN is defined.
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DWIDTH  = 8,
  parameter int DEPTH   = 4,
  parameter int OCC_W   = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*DWIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  input  logic                        fifo_read,
  output logic                        fifo_write,
  output logic [DWIDTH-1:0]           fifo_wrdata,
  output logic                        busy,
`ifdef FIFO_WR_ARB_CNT_EN
  output logic [15:0]                 beat_cnt,
  output logic [15:0]                 pkt_cnt,
`endif
  output logic                        state_dbg,
  output logic [OCC_W-1:0]            occ_dbg,
  output logic [$clog2(NUM_REQ)-1:0]  rr_ptr_dbg
);

  localparam int PTR_W = $clog2(NUM_REQ);

  // Handshake: a requester holds req/req_last/req_data stable until gnt;
  // a beat transfers in the cycle where req[i] & gnt[i] are both high.

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               fifo_write_q;
  logic [DWIDTH-1:0]  fifo_wrdata_q, fifo_wrdata_d;
  logic               busy_q, busy_d;

  logic [DWIDTH-1:0]  data_a [NUM_REQ];
  logic [PTR_W-1:0]   sel;
  logic               found;
  logic               space;
  logic               accept;
  logic               sel_last;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_a[i] = req_data[i*DWIDTH +: DWIDTH];
  end

  function automatic logic [PTR_W-1:0] inc_wrap(input logic [PTR_W-1:0] v);
    if (v == PTR_W'(NUM_REQ - 1)) return '0;
    return v + 1'b1;
  endfunction

  // occ counts from acceptance, so it runs one cycle ahead of the FIFO's own pointers
  assign space = (occ_q < OCC_W'(DEPTH));

  always_comb begin
    int               tmp;
    logic [PTR_W-1:0] idx;
    sel   = '0;
    found = 1'b0;
    tmp   = 0;
    idx   = '0;
    if (state_q == IDLE) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        tmp = int'(rr_ptr_q) + k;
        if (tmp >= NUM_REQ) tmp = tmp - NUM_REQ;
        idx = PTR_W'(tmp);
        if (!found && req[idx]) begin
          found = 1'b1;
          sel   = idx;
        end
      end
    end else begin
      sel   = owner_q;
      found = req[owner_q];
    end
  end

  assign accept   = found & space & reset;
  assign sel_last = req_last[sel];

  always_comb begin
    gnt = '0;
    if (accept) gnt[sel] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    fifo_wrdata_d = fifo_wrdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (sel_last) begin
            rr_ptr_d = inc_wrap(sel);
          end else begin
            owner_d = sel;
            state_d = BURST;
          end
        end
      end
      BURST: begin
        if (accept && sel_last) begin
          state_d  = IDLE;
          rr_ptr_d = inc_wrap(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) fifo_wrdata_d = data_a[sel];
    busy_d = (state_d == BURST);
    occ_d  = occ_q + OCC_W'(accept) - OCC_W'(fifo_read && (occ_q != '0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      occ_q         <= '0;
      fifo_write_q  <= 1'b0;
      fifo_wrdata_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      occ_q         <= occ_d;
      fifo_write_q  <= accept;
      fifo_wrdata_q <= fifo_wrdata_d;
      busy_q        <= busy_d;
    end
  end

`ifdef FIFO_WR_ARB_CNT_EN
  logic [15:0] beat_cnt_q;
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_q + 16'(accept);
      pkt_cnt_q  <= pkt_cnt_q + 16'(accept & sel_last);
    end
  end

  assign beat_cnt = beat_cnt_q;
  assign pkt_cnt  = pkt_cnt_q;
`endif

  assign fifo_write  = fifo_write_q;
  assign fifo_wrdata = fifo_wrdata_q;
  assign busy        = busy_q;
  assign state_dbg   = state_q;
  assign occ_dbg     = occ_q;
  assign rr_ptr_dbg  = rr_ptr_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: round robin, packet atomicity, full stall,
// occupancy corner cases and async reset; counter checks when FIFO_WR_ARB_CNT_EN is defined.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_read;
  logic        fifo_write;
  logic [7:0]  fifo_wrdata;
  logic        busy;
`ifdef FIFO_WR_ARB_CNT_EN
  logic [15:0] beat_cnt;
  logic [15:0] pkt_cnt;
`endif
  logic        state_dbg;
  logic [2:0]  occ_dbg;
  logic [1:0]  rr_ptr_dbg;

  int          n_total = 0;
  int          n_bad   = 0;
  logic        sb_en   = 1'b1;
  logic [7:0]  exp_q[$];

  logic [3:0]  t1_gnt [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
  logic        t1_wr  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0]  t1_dat [6] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h13};

  fifo_wr_arbiter #(.NUM_REQ(4), .DWIDTH(8), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_last    (req_last),
    .req_data    (req_data),
    .gnt         (gnt),
    .fifo_read   (fifo_read),
    .fifo_write  (fifo_write),
    .fifo_wrdata (fifo_wrdata),
    .busy        (busy),
`ifdef FIFO_WR_ARB_CNT_EN
    .beat_cnt    (beat_cnt),
    .pkt_cnt     (pkt_cnt),
`endif
    .state_dbg   (state_dbg),
    .occ_dbg     (occ_dbg),
    .rr_ptr_dbg  (rr_ptr_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d,
                       input logic rd);
    req       = r;
    req_last  = l;
    req_data  = d;
    fifo_read = rd;
  endtask

  // scoreboard: every FIFO write must match the next expected beat
  always @(negedge clk) begin
    if (reset && sb_en && fifo_write) begin
      if (exp_q.size() == 0) check("sb_pending", 32'(exp_q.size()), 32'd1);
      else                   check("sb_data", 32'(fifo_wrdata), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    reset = 1'b0;
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);
    @(negedge clk);
    drive(4'b1111, 4'b1111, 32'h13121110, 1'b0);
    #1;
    check("rst_gnt",    32'(gnt), 32'd0);
    check("rst_write",  32'(fifo_write), 32'd0);
    check("rst_wrdata", 32'(fifo_wrdata), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_occ",    32'(occ_dbg), 32'd0);
    check("rst_rr",     32'(rr_ptr_dbg), 32'd0);
    check("rst_state",  32'(state_dbg), 32'd0);
    @(negedge clk);

    // single-beat round robin
    exp_q.push_back(8'h10); exp_q.push_back(8'h11);
    exp_q.push_back(8'h12); exp_q.push_back(8'h13);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("rr_gnt",   32'(gnt), 32'(t1_gnt[c]));
      check("rr_write", 32'(fifo_write), 32'(t1_wr[c]));
      if (c > 0) check("rr_wrdata", 32'(fifo_wrdata), 32'(t1_dat[c]));
      @(negedge clk);
    end
    check("rr_occ_full", 32'(occ_dbg), 32'd4);
    drive(4'b0000, 4'b0000, 32'h0, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    check("drain_occ", 32'(occ_dbg), 32'd0);
    check("rr_wrap",   32'(rr_ptr_dbg), 32'd0);
    @(negedge clk);

    // packet atomicity: req0 three beats, req1 single beat
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2); exp_q.push_back(8'hB0);
    drive(4'b0011, 4'b0010, 32'h0000B0A0, 1'b1);
    #1; check("pk_gnt1", 32'(gnt), 32'b0001); check("pk_busy1", 32'(busy), 32'd0);
    @(negedge clk);
    drive(4'b0011, 4'b0010, 32'h0000B0A1, 1'b1);
    #1; check("pk_gnt2", 32'(gnt), 32'b0001); check("pk_busy2", 32'(busy), 32'd1);
    @(negedge clk);
    drive(4'b0011, 4'b0011, 32'h0000B0A2, 1'b1);
    #1; check("pk_gnt3", 32'(gnt), 32'b0001); check("pk_busy3", 32'(busy), 32'd1);
    @(negedge clk);
    drive(4'b0010, 4'b0010, 32'h0000B000, 1'b1);
    #1; check("pk_gnt4", 32'(gnt), 32'b0010); check("pk_busy4", 32'(busy), 32'd0);
    check("pk_state4", 32'(state_dbg), 32'd0);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 32'h0, 1'b1);
    #1; check("pk_gnt5", 32'(gnt), 32'd0); check("pk_occ5", 32'(occ_dbg), 32'd1);
    @(negedge clk);
    #1; check("pk_occ6", 32'(occ_dbg), 32'd0); check("pk_rr", 32'(rr_ptr_dbg), 32'd2);
    check("pk_write6", 32'(fifo_write), 32'd0);

    // full stall: fill from req0, then req2 waits for space
    exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
    exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
    exp_q.push_back(8'h5A);
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      drive(4'b0001, 4'b0001, 32'(8'hC0 + b), 1'b0);
      #1; check("fill_gnt", 32'(gnt), 32'b0001);
      @(negedge clk);
    end
    drive(4'b0100, 4'b0100, 32'h005A0000, 1'b0);
    #1; check("full_gnt1", 32'(gnt), 32'd0); check("full_occ", 32'(occ_dbg), 32'd4);
    @(negedge clk);
    drive(4'b0100, 4'b0100, 32'h005A0000, 1'b1);
    #1; check("full_gnt_rd", 32'(gnt), 32'd0);
    @(negedge clk);
    drive(4'b0100, 4'b0100, 32'h005A0000, 1'b0);
    #1; check("full_gnt_go", 32'(gnt), 32'b0100); check("full_occ3", 32'(occ_dbg), 32'd3);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);
    #1; check("full_write", 32'(fifo_write), 32'd1);
    check("full_wrdata", 32'(fifo_wrdata), 32'h5A);
    check("full_occ4", 32'(occ_dbg), 32'd4);
    @(negedge clk);

    // simultaneous accept+read, then read at empty
    exp_q.push_back(8'hD0);
    drive(4'b0000, 4'b0000, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    drive(4'b0001, 4'b0001, 32'h000000D0, 1'b1);
    #1; check("ar_occ_pre", 32'(occ_dbg), 32'd2); check("ar_gnt", 32'(gnt), 32'b0001);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);
    #1; check("ar_occ_post", 32'(occ_dbg), 32'd2);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    #1; check("empty_occ", 32'(occ_dbg), 32'd0); check("empty_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    #1; check("uflow_occ", 32'(occ_dbg), 32'd0);
    @(negedge clk);

    // async reset in the middle of a burst at occ=3
    exp_q.push_back(8'hE0); exp_q.push_back(8'hE1); exp_q.push_back(8'hE2);
    drive(4'b0010, 4'b0000, 32'h0000E000, 1'b0);
    #1; check("rb_gnt1", 32'(gnt), 32'b0010);
    @(negedge clk);
    drive(4'b0010, 4'b0000, 32'h0000E100, 1'b0);
    #1; check("rb_gnt2", 32'(gnt), 32'b0010);
    @(negedge clk);
    drive(4'b0010, 4'b0000, 32'h0000E200, 1'b0);
    @(negedge clk);
    drive(4'b0010, 4'b0000, 32'h0000E300, 1'b0);
    #1;
    check("rb_pre_gnt",   32'(gnt), 32'b0010);
    check("rb_pre_busy",  32'(busy), 32'd1);
    check("rb_pre_write", 32'(fifo_write), 32'd1);
    check("rb_pre_occ",   32'(occ_dbg), 32'd3);
    #1 reset = 1'b0;
    #1;
    check("rb_gnt",   32'(gnt), 32'd0);
    check("rb_busy",  32'(busy), 32'd0);
    check("rb_write", 32'(fifo_write), 32'd0);
    check("rb_occ",   32'(occ_dbg), 32'd0);
    check("rb_state", 32'(state_dbg), 32'd0);
    check("rb_rr",    32'(rr_ptr_dbg), 32'd0);
    drive(4'b1111, 4'b1111, 32'hF3F2F1F0, 1'b0);
    #1; check("rb_hold_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    exp_q.push_back(8'hF0);
    reset = 1'b1;
    #1; check("rb_first_gnt", 32'(gnt), 32'b0001);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);
    #1; check("rb_first_write", 32'(fifo_write), 32'd1);
    check("rb_first_data", 32'(fifo_wrdata), 32'hF0);
    @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_WR_ARB_CNT_EN
    sb_en = 1'b0;
    reset = 1'b0;
    drive(4'b0001, 4'b0001, 32'h00000077, 1'b1);
    #1; check("cnt_rst_beat", 32'(beat_cnt), 32'd0); check("cnt_rst_pkt", 32'(pkt_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (70000) @(negedge clk);
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);
    #1;
    check("cnt_beat", 32'(beat_cnt), 32'd4464);
    check("cnt_pkt",  32'(pkt_cnt), 32'd4464);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-atomic write arbiter that shares one local FIFO write port (fifo_N_M style, DEPTH entries) between NUM_REQ producers.
- Sits directly in front of the FIFO and drives its write/wrdata.
- Keeps its own occupancy credit counter, so a write is never issued into a full FIFO despite the FIFO's registered full flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DWIDTH, 8, data width per beat; must match FIFO width.
- DEPTH, 4, FIFO depth in entries (power of two).
- OCC_W, $clog2(DEPTH)+1, occupancy counter width (derived; do not override).

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  asynchronous, active-low; reset=0 clears all state immediately.
- req  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester: current beat is the final beat of its packet.
- req_data  in  NUM_REQ*DWIDTH  beat data; requester i owns bits [i*DWIDTH +: DWIDTH].
- gnt  out  NUM_REQ  one-hot, combinational; gnt[i]=1 means requester i's beat is accepted this cycle.
- fifo_read  in  1  consumer read strobe on the FIFO; one entry freed.
- fifo_write  out  1  registered FIFO write enable.
- fifo_wrdata  out  DWIDTH  registered FIFO write data.
- busy  out  1  registered; 1 while a multi-beat packet owns the port (state BURST).

Behaviour:
- Reset values: fifo_write=0, fifo_wrdata=0, busy=0, state=IDLE, rr_ptr=0, owner=0, occ=0. gnt=0 while reset=0.
- Handshake: a requester holds req, req_last and req_data stable until it sees gnt. At most one gnt bit is set per cycle.
- space = (occ < DEPTH). The arbiter never grants when space=0; a read in the same cycle is not bypassed.
- State IDLE:
  - Select the first i with req[i]=1, searching circularly from rr_ptr.
  - If space, assert gnt[i].
  - If req_last[i]=1: stay IDLE, rr_ptr <= (i+1) mod NUM_REQ.
  - Otherwise: owner <= i, go to BURST.
- State BURST:
  - Only owner is eligible; gnt[owner] = req[owner] & space. Other requesters are ignored.
  - On an accepted beat with req_last[owner]=1: go to IDLE, rr_ptr <= (owner+1) mod NUM_REQ.
  - A gap (req[owner]=0) holds BURST indefinitely.
- Output latency: an accepted beat in cycle t appears on fifo_write=1 / fifo_wrdata in cycle t+1. fifo_write=0 otherwise; fifo_wrdata holds its last value.
- Occupancy:
  - occ_next = occ + accept - (fifo_read & (occ != 0)).
  - Simultaneous accept and read leaves occ unchanged.
  - A read at occ=0 is ignored (no underflow).
  - occ counts beats from acceptance, so it leads the FIFO's own pointers by one cycle. This is conservative and cannot overflow.
- Reset mid-packet: returns to IDLE, drops the burst, and zeroes occ. The FIFO must share the same reset.
- NUM_REQ not a power of two: rr_ptr wraps explicitly at NUM_REQ-1.

Optional Feature:
- Macro: FIFO_WR_ARB_CNT_EN.
- Defined: adds output beat_cnt [15:0].
  - Registered count of accepted beats; reset 0.
  - Increments on each accept and wraps 16'hFFFF -> 0.
  - Adds output pkt_cnt [15:0], counting accepted last beats, with the same rules.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
- Single-beat round robin: req=4'b1111, req_last=4'b1111, data i=8'h10+i, fifo_read=0 -> gnt order 0001,0010,0100,1000 on cycles 1-4. fifo_write writes 10,11,12,13 on cycles 2-5. Cycle 5: gnt=0 (occ=4).
- Packet atomicity: req0 3-beat packet (A0,A1,A2 last) and req1 single beat B0 asserted together, fifo_read=1 every cycle -> FIFO receives A0,A1,A2,B0. gnt[1] stays 0 until A2 is accepted. busy=1 for the 2 cycles after A0.
- Full stall: fill to occ=4, hold req2 with data 8'h5A -> gnt=0. Pulse fifo_read once -> gnt[2]=1 the following cycle, fifo_write with 5A one cycle later, occ returns to 4.
- Simultaneous accept+read at occ=2 -> occ stays 2. fifo_read at occ=0 -> occ stays 0, no gnt side effect.
- Async reset mid-burst: assert reset=0 between clock edges while in BURST with occ=3 -> busy, fifo_write and gnt drop immediately without a clock edge. After release, rr_ptr=0 and requester 0 wins first.
- With FIFO_WR_ARB_CNT_EN: run 70000 single-beat accepts -> beat_cnt = 70000 mod 65536 = 4464 and pkt_cnt = 4464.
